// File: rtl/cpu_pkg.sv
// cpu_pkg: condition codes, comparator flag indices and branch FSM states shared by the CPU blocks.
package cpu_pkg;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_NE     = 3'd2;
    localparam logic [2:0] COND_GT     = 3'd3;
    localparam logic [2:0] COND_LT     = 3'd4;
    localparam logic [2:0] COND_GE     = 3'd5;
    localparam logic [2:0] COND_LE     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    // LT is encoded as neither EQ nor GT being set.
    localparam int FLAG_EQ = 0;
    localparam int FLAG_GT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_COMMIT
    } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational condition-code test against the EQ/GT comparator flags.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [1:0] flags_i,
    output logic       taken_o
);

    logic eq;
    logic gt;

    assign eq = flags_i[FLAG_EQ];
    assign gt = flags_i[FLAG_GT];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_ALWAYS: taken_o = 1'b1;
            COND_EQ:     taken_o = eq;
            COND_NE:     taken_o = !eq;
            COND_GT:     taken_o = gt;
            COND_LT:     taken_o = !eq && !gt;
            COND_GE:     taken_o = eq || gt;
            COND_LE:     taken_o = !gt;
            COND_NEVER:  taken_o = 1'b0;
            default:     taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: owns the PC, resolves conditional branches over IDLE/EVAL/COMMIT and pulses done/flush.
// Define BRANCH_STATS_EN to add a saturating taken_count output.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] target,
    input  logic             step,
    input  logic [WIDTH-1:0] flags,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             taken,
    output logic             done,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      taken_count
`endif
);

    br_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [2:0]       cond_q, cond_d;
    logic [1:0]       flags_q, flags_d;
    logic             taken_q, taken_d;
    logic             done_q, done_d;
    logic             flush_q, flush_d;
    logic             eval_taken;
    logic [WIDTH-1:0] pc_inc;
    logic             unused_flags;

    // Only EQ and GT carry meaning; the rest of the comparator word is dropped.
    assign unused_flags = ^flags[WIDTH-1:2];
    assign pc_inc       = pc_q + WIDTH'(1);

    branch_cond_eval u_cond_eval (
        .cond_i  (cond_q),
        .flags_i (flags_q),
        .taken_o (eval_taken)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        cond_d   = cond_q;
        flags_d  = flags_q;
        taken_d  = taken_q;
        done_d   = 1'b0;
        flush_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (branch) begin
                    cond_d   = cond;
                    target_d = target;
                    flags_d  = flags[1:0];
                    state_d  = ST_EVAL;
                end else if (step) begin
                    pc_d = pc_inc;
                end
            end
            ST_EVAL: begin
                taken_d = eval_taken;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                pc_d    = taken_q ? target_q : pc_inc;
                done_d  = 1'b1;
                flush_d = taken_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            target_q <= '0;
            cond_q   <= COND_NEVER;
            flags_q  <= '0;
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cond_q   <= cond_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
            done_q   <= done_d;
            flush_q  <= flush_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] count_q, count_d;

    assign count_d = (state_q == ST_COMMIT && taken_q && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign taken_count = count_q;
`endif

    assign pc    = pc_q;
    assign busy  = (state_q != ST_IDLE);
    assign taken = taken_q;
    assign done  = done_q;
    assign flush = flush_q;

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer of the comparator flag word: snapshots `flags`, evaluates a 3-bit condition code and resolves conditional jumps.
- Owns the program counter: either loads the branch target or falls through to PC+1.
- Sits between the instruction decoder and the PC/fetch path; raises `flush` so fetch discards prefetched work on a taken branch.

Parameters:
- WIDTH, 16, width of PC, target and flag word.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- branch  input  1  strobe: resolve a branch this cycle (sampled only in IDLE).
- cond  input  3  condition code, captured with `branch`.
- target  input  WIDTH  jump address, captured with `branch`.
- step  input  1  sequential advance: PC+1 (honoured only in IDLE).
- flags  input  WIDTH  comparator flag word; bit0 = EQ, bit1 = GT (A>B); LT is neither bit set; bits 15:2 ignored.
- pc  output  WIDTH  current program counter.
- busy  output  1  branch in progress.
- taken  output  1  result of the last resolved branch; held until the next resolution.
- done  output  1  one-cycle pulse when PC is committed.
- flush  output  1  one-cycle pulse, concurrent with `done`, only when the branch is taken.

Behaviour:
- Reset (synchronous, any state):
  - pc = RESET_PC; busy = taken = done = flush = 0; state = IDLE.
  - An in-flight branch is discarded, with no `done` and no `flush`.
- Condition codes:
  - 0 ALWAYS; 1 EQ (bit0); 2 NE (!bit0); 3 GT (bit1).
  - 4 LT (!bit0 & !bit1); 5 GE (bit0 | bit1); 6 LE (!bit1); 7 NEVER.
- FSM states IDLE, EVAL, COMMIT:
  - IDLE:
    - `branch`=1 at edge E0 captures cond, target and a flags snapshot; next state EVAL; busy=1 from E0.
    - Otherwise, if `step`=1: pc <= pc+1.
    - `branch` and `step` together: `branch` wins and `step` is dropped.
  - EVAL: evaluate the captured cond against the snapshot; register the result into `taken` at E1; next state COMMIT.
  - COMMIT (edge E2):
    - pc <= target if taken, else pc+1.
    - done=1 for the cycle after E2; flush=1 for that cycle only if taken.
    - busy=0 after E2; next state IDLE.
- Latency: exactly 2 edges from the `branch` sample to the PC update; a new `branch` is accepted in the cycle `done` is high.
- `flags` changes after E0 have no effect; only the snapshot is used.
- `branch` and `step` are ignored while busy: no queueing, no error.
- Arithmetic:
  - pc+1 is WIDTH-bit modulo; 16'hFFFF wraps to 16'h0000, with no carry output.
  - `target` is used as given, with no alignment check.
- `taken` is unaffected by `step`.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds output `taken_count` (16 bits).
  - Increments in COMMIT when taken; saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package `cpu_pkg`:
  - condition-code constants (COND_ALWAYS..COND_NEVER);
  - flag bit indices FLAG_EQ=0, FLAG_GT=1;
  - the FSM state enum.
  - The comparator uses the same flag indices.
- One sub-module: `branch_cond_eval`, combinational (cond, flags snapshot) -> taken, instanced once, to be reused by the decoder's skip instructions.

Test Plan:
- Reset, then step x3: pc = 0x0003; busy, done and flush stay 0 throughout.
- Taken EQ: pc=0x0010, flags=0x0001, branch with cond=1, target=0x0200.
  - busy high for 2 cycles.
  - Then pc=0x0200, taken=1, done=1 and flush=1 for exactly one cycle.
- Not-taken GT: flags=0x0000, cond=3, pc=0x0010 -> pc=0x0011, taken=0, done=1, flush=0.
- Flags snapshot:
  - branch cond=4 (LT) with flags=0x0000; change flags to 0x0002 during EVAL.
  - Required: taken=1, pc=target.
- Wrap and priority:
  - pc=0xFFFF with step -> pc=0x0000.
  - branch and step in the same cycle -> only the branch executes; step and branch while busy are ignored.
- Reset mid-operation: assert reset during EVAL -> pc=RESET_PC, busy=0, no done or flush pulse. With BRANCH_STATS_EN, taken_count=0.
